sram_rr_arbiter: RTL and testbench

Two-requester round-robin arbiter and sequencer for the single-port SRAM model. It accepts one read or write command at a time from either requester, drives the SRAM read/write/strobe/address/data pins for exactly one cycle, and waits for SRAM rvalid on reads. It then returns a per-requester response pulse, with error signalling if a read times out. It sits between APB4 slave logic (or other masters) and the SRAM.

---
 rtl/sram_rr_arbiter.sv | 171 +++++++++++++++++
 tb/tb_sram_rr_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_rr_arbiter.sv
// sram_rr_arbiter: two-requester round-robin arbiter/sequencer for a 1-port SRAM.
// Ports: req/we/addr/wdata/strb per requester in; gnt/resp per requester, resp_err, rdata, busy out; mem_* to/from SRAM.
module sram_rr_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int RD_TIMEOUT = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  input  logic [STRB_WIDTH-1:0] strb0,
  input  logic [STRB_WIDTH-1:0] strb1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  resp0,
  output logic                  resp1,
  output logic                  resp_err,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [STRB_WIDTH-1:0] mem_strb,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_rvalid
);

  localparam int CW = (RD_TIMEOUT > 2) ? $clog2(RD_TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RDWAIT,
    RESP
  } state_t;

  state_t          state, state_d;
  logic            last, last_d;
  logic            win, win_d;
  logic            we_q, we_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic            pick;

  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] wdata_d;
  logic [STRB_WIDTH-1:0] strb_d;
  logic [DATA_WIDTH-1:0] rdata_d;
  logic rd_d, wr_d, g0_d, g1_d;
  logic r0_d, r1_d, err_d, busy_d;

  always_comb begin
    state_d = state;
    last_d  = last;
    win_d   = win;
    we_d    = we_q;
    cnt_d   = cnt;
    addr_d  = mem_addr;
    wdata_d = mem_wdata;
    strb_d  = mem_strb;
    rdata_d = rdata;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    g0_d    = 1'b0;
    g1_d    = 1'b0;
    r0_d    = 1'b0;
    r1_d    = 1'b0;
    err_d   = 1'b0;
    // On a tie requester 1 wins only if 0 was granted last.
    pick    = req1 & (~req0 | ~last);
    unique case (state)
      IDLE: begin
        if (req0 | req1) begin
          state_d = ACCESS;
          last_d  = pick;
          win_d   = pick;
          we_d    = pick ? we1 : we0;
          addr_d  = pick ? addr1 : addr0;
          wdata_d = pick ? wdata1 : wdata0;
          strb_d  = pick ? strb1 : strb0;
          wr_d    = pick ? we1 : we0;
          rd_d    = pick ? ~we1 : ~we0;
          g0_d    = ~pick;
          g1_d    = pick;
        end
      end
      ACCESS: begin
        cnt_d = '0;
        if (we_q) begin
          state_d = RESP;
          r0_d    = ~win;
          r1_d    = win;
        end else begin
          state_d = RDWAIT;
        end
      end
      RDWAIT: begin
        if (mem_rvalid) begin
          state_d = RESP;
          rdata_d = mem_rdata;
          r0_d    = ~win;
          r1_d    = win;
        end else if (cnt == CW'(RD_TIMEOUT - 1)) begin
          state_d = RESP;
          rdata_d = '0;
          err_d   = 1'b1;
          r0_d    = ~win;
          r1_d    = win;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      last      <= 1'b1;
      win       <= 1'b0;
      we_q      <= 1'b0;
      cnt       <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_strb  <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      rdata     <= '0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      resp0     <= 1'b0;
      resp1     <= 1'b0;
      resp_err  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      last      <= last_d;
      win       <= win_d;
      we_q      <= we_d;
      cnt       <= cnt_d;
      mem_addr  <= addr_d;
      mem_wdata <= wdata_d;
      mem_strb  <= strb_d;
      mem_read  <= rd_d;
      mem_write <= wr_d;
      rdata     <= rdata_d;
      gnt0      <= g0_d;
      gnt1      <= g1_d;
      resp0     <= r0_d;
      resp1     <= r1_d;
      resp_err  <= err_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// tb_sram_rr_arbiter: scoreboard bench with SRAM stub and reference model.
// Ports: none.
module tb_sram_rr_arbiter;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int SW = 4;
  localparam int TO = 4;

  logic clk = 0;
  logic rstn = 0;
  logic req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [AW-1:0] addr0 = 0, addr1 = 0;
  logic [DW-1:0] wdata0 = 0, wdata1 = 0;
  logic [SW-1:0] strb0 = 0, strb1 = 0;
  logic gnt0, gnt1, resp0, resp1, resp_err, busy;
  logic [DW-1:0] rdata;
  logic [AW-1:0] mem_addr;
  logic mem_read, mem_write;
  logic [SW-1:0] mem_strb;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = 0;
  logic mem_rvalid = 0;

  sram_rr_arbiter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .STRB_WIDTH(SW), .RD_TIMEOUT(TO)
  ) dut (
    .clk(clk), .rstn(rstn),
    .req0(req0), .req1(req1),
    .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .strb0(strb0), .strb1(strb1),
    .gnt0(gnt0), .gnt1(gnt1),
    .resp0(resp0), .resp1(resp1),
    .resp_err(resp_err), .rdata(rdata),
    .busy(busy),
    .mem_addr(mem_addr), .mem_read(mem_read),
    .mem_write(mem_write), .mem_strb(mem_strb),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_rvalid(mem_rvalid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM stub: registered read, rvalid one cycle after mem_read.
  logic [DW-1:0] sram [256];
  bit stall = 0;
  always @(posedge clk) begin
    mem_rvalid <= 1'b0;
    if (mem_write)
      for (int b = 0; b < SW; b++)
        if (mem_strb[b]) sram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
    if (mem_read && !stall) begin
      mem_rdata  <= sram[mem_addr];
      mem_rvalid <= 1'b1;
    end
  end

  typedef struct {
    bit id; bit we;
    logic [AW-1:0] a; logic [DW-1:0] d; logic [SW-1:0] s;
    logic [DW-1:0] rd; bit err; int lat; int gc;
  } exp_t;

  typedef struct {
    bit we; logic [AW-1:0] a; logic [DW-1:0] d; logic [SW-1:0] s;
  } cmd_t;

  exp_t gq[$];
  exp_t rq[$];
  int total = 0;
  int bad = 0;
  int nresp = 0;
  int ngnt = 0;

  // reference model state
  logic [DW-1:0] mdl [256];
  bit mlast = 1;
  logic [DW-1:0] last_rd = 0;

  bit cont_on = 0;
  int cont_n = 0;
  int cont_last = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic cmd_t mk(bit we, int a, logic [DW-1:0] d, int s);
    cmd_t c;
    c.we = we; c.a = AW'(a); c.d = d; c.s = SW'(s);
    return c;
  endfunction

  task automatic push(bit id, cmd_t c, bit to);
    exp_t e;
    e.id = id; e.we = c.we; e.a = c.a; e.d = c.d; e.s = c.s;
    e.gc = 0;
    if (c.we) begin
      for (int b = 0; b < SW; b++)
        if (c.s[b]) mdl[c.a][b*8 +: 8] = c.d[b*8 +: 8];
      e.rd = last_rd; e.err = 0; e.lat = 1;
    end else if (to) begin
      last_rd = 0;
      e.rd = 0; e.err = 1; e.lat = TO + 1;
    end else begin
      last_rd = mdl[c.a];
      e.rd = last_rd; e.err = 0; e.lat = 2;
    end
    gq.push_back(e);
  endtask

  task automatic drive(bit r0, bit r1, cmd_t c0, cmd_t c1);
    req0 = r0; we0 = c0.we; addr0 = c0.a; wdata0 = c0.d; strb0 = c0.s;
    req1 = r1; we1 = c1.we; addr1 = c1.a; wdata1 = c1.d; strb1 = c1.s;
  endtask

  // One or two commands issued together from an idle arbiter.
  task automatic round(bit r0, bit r1, cmd_t c0, cmd_t c1, bit to);
    int tgt, t0;
    bit first;
    @(negedge clk);
    if (r0 && r1) begin
      if (mlast) begin push(0, c0, to); push(1, c1, to); end
      else begin push(1, c1, to); push(0, c0, to); end
    end else if (r0) begin
      push(0, c0, to); mlast = 0;
    end else begin
      push(1, c1, to); mlast = 1;
    end
    tgt = nresp + (r0 ? 1 : 0) + (r1 ? 1 : 0);
    stall = to;
    t0 = cyc;
    first = 1;
    drive(r0, r1, c0, c1);
    for (int k = 0; k < 40 && nresp != tgt; k++) begin
      @(negedge clk);
      if ((gnt0 || gnt1) && first) begin
        chk("gnt_lat", 64'(cyc - t0), 1);
        first = 0;
      end
      if (gnt0) req0 = 0;
      if (gnt1) req1 = 0;
    end
    chk("round_done", 64'(nresp), 64'(tgt));
    req0 = 0; req1 = 0; stall = 0;
  endtask

  exp_t e;
  always @(negedge clk) begin
    if (rstn) begin
      if (mem_read && mem_write) chk("rw_both", 1, 0);
      if (gnt0 && gnt1) chk("gnt_both", 1, 0);
      if (resp0 && resp1) chk("resp_both", 1, 0);
      if (gnt0 || gnt1) begin
        ngnt++;
        if (gq.size() == 0) chk("gnt_unexpected", 1, 0);
        else begin
          e = gq.pop_front();
          chk("gnt_id", 64'(gnt1), 64'(e.id));
          chk("mem_op", {mem_write, mem_read}, {e.we, !e.we});
          chk("mem_addr", mem_addr, e.a);
          chk("busy", busy, 1);
          if (e.we) begin
            chk("mem_wdata", mem_wdata, e.d);
            chk("mem_strb", mem_strb, e.s);
          end
          e.gc = cyc;
          rq.push_back(e);
          if (cont_on) begin
            if (cont_n > 0) chk("gnt_gap", 64'(cyc - cont_last), 4);
            cont_last = cyc;
            cont_n++;
          end
        end
      end else if (mem_read || mem_write) begin
        chk("mem_op_idle", 1, 0);
      end
      if (resp0 || resp1) begin
        nresp++;
        if (rq.size() == 0) chk("resp_unexpected", 1, 0);
        else begin
          e = rq.pop_front();
          chk("resp_id", 64'(resp1), 64'(e.id));
          chk("resp_err", resp_err, e.err);
          chk("rdata", rdata, e.rd);
          chk("resp_lat", 64'(cyc - e.gc), 64'(e.lat));
        end
      end else if (resp_err) begin
        chk("err_stray", 1, 0);
      end
    end
  end

  cmd_t z, c0, c1;
  initial begin
    for (int i = 0; i < 256; i++) begin
      sram[i] = 0; mdl[i] = 0;
    end
    z = mk(0, 0, 0, 0);
    drive(0, 0, z, z);
    rstn = 0;
    repeat (2) @(negedge clk);
    chk("rst_pulses", {gnt0, gnt1, resp0, resp1, resp_err, busy}, 0);
    chk("rst_mem_ctl", {mem_read, mem_write, mem_strb}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rdata", rdata, 0);
    rstn = 1;

    round(1, 0, mk(1, 'h10, 32'hDEADBEEF, 'hF), z, 0);
    round(0, 1, z, mk(0, 'h10, 0, 0), 0);
    chk("readback", rdata, 32'hDEADBEEF);
    round(1, 0, mk(1, 'h20, 32'hDEADBEEF, 'hF), z, 0);
    round(0, 1, z, mk(1, 'h20, 32'h11223344, 'h3), 0);
    round(1, 0, mk(0, 'h20, 0, 0), z, 0);
    chk("partial", rdata, 32'hDEAD3344);

    // Both held high with reads: grants alternate every 4 cycles.
    @(negedge clk);
    c0 = mk(0, 'h10, 0, 0);
    c1 = mk(0, 'h20, 0, 0);
    for (int i = 0; i < 6; i++) begin
      if (mlast) begin push(0, c0, 0); mlast = 0; end
      else begin push(1, c1, 0); mlast = 1; end
    end
    cont_n = 0; cont_on = 1;
    begin
      int g0, r0t;
      g0 = ngnt; r0t = nresp + 6;
      drive(1, 1, c0, c1);
      for (int k = 0; k < 60 && ngnt < g0 + 6; k++) @(negedge clk);
      drive(0, 0, z, z);
      for (int k = 0; k < 20 && nresp < r0t; k++) @(negedge clk);
      chk("cont_grants", 64'(ngnt - g0), 6);
      chk("cont_done", 64'(nresp), 64'(r0t));
    end
    cont_on = 0;

    round(1, 0, mk(0, 'h10, 0, 0), z, 1);
    chk("timeout_rdata", rdata, 0);
    round(0, 1, z, mk(0, 'h10, 0, 0), 0);

    for (int i = 0; i < 40; i++) begin
      int pat;
      pat = $urandom_range(1, 3);
      c0 = mk($urandom_range(0, 1), $urandom_range(0, 15),
              $urandom, $urandom_range(0, 15));
      c1 = mk($urandom_range(0, 1), $urandom_range(0, 15),
              $urandom, $urandom_range(0, 15));
      round(pat[0], pat[1], c0, c1, $urandom_range(0, 7) == 0);
    end

    // Reset during RDWAIT abandons the read.
    @(negedge clk);
    stall = 1;
    c0 = mk(0, 'h10, 0, 0);
    push(0, c0, 1);
    drive(1, 0, c0, z);
    for (int k = 0; k < 10 && !gnt0; k++) @(negedge clk);
    chk("mid_gnt", gnt0, 1);
    req0 = 0;
    @(negedge clk);
    rstn = 0;
    gq.delete(); rq.delete();
    mlast = 1; last_rd = 0;
    @(negedge clk);
    chk("mid_busy", busy, 0);
    chk("mid_resp", {resp0, resp1, resp_err}, 0);
    rstn = 1;
    stall = 0;
    round(1, 1, mk(0, 'h20, 0, 0), mk(0, 'h10, 0, 0), 0);

    repeat (3) @(negedge clk);
    chk("gq_empty", 64'(gq.size()), 0);
    chk("rq_empty", 64'(rq.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
